// File: rtl/rtc_bus_sequencer_if.sv
// ----------------------------------------------------------------------------
// rtc_bus_sequencer_if
//
// Purpose:
//   Bundles the requester handshake and the RTC multiplexed address/data bus
//   signals of rtc_bus_sequencer into one interface.
//
// Signal summary:
//   rd_req / rd_addr              read requester (level request, register addr)
//   wr_req / wr_addr / wr_data    write requester (level request, addr, data)
//   grant_rd / grant_wr           one-cycle accept pulses
//   done / busy                   transaction end pulse, not-idle status
//   rd_data                       last read result
//   cs_n, rd_n, wr_n, ad_n        RTC strobes (ad_n=0: bus carries an address)
//   ad_oe / ad_out / ad_in        tristate enable, driven value, sampled value
//
// Modports:
//   master  requesters plus the RTC pad side (drive requests and ad_in)
//   slave   the sequencer itself
// ----------------------------------------------------------------------------
interface rtc_bus_sequencer_if;
    logic       rd_req;
    logic [7:0] rd_addr;
    logic       wr_req;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       grant_rd;
    logic       grant_wr;
    logic       done;
    logic       busy;
    logic [7:0] rd_data;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       ad_n;
    logic       ad_oe;
    logic [7:0] ad_out;
    logic [7:0] ad_in;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data, ad_in,
        input  grant_rd, grant_wr, done, busy, rd_data,
               cs_n, rd_n, wr_n, ad_n, ad_oe, ad_out
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data, ad_in,
        output grant_rd, grant_wr, done, busy, rd_data,
               cs_n, rd_n, wr_n, ad_n, ad_oe, ad_out
    );
endinterface

// File: rtl/rtc_bus_sequencer.sv
// ----------------------------------------------------------------------------
// rtc_bus_sequencer
//
// Purpose:
//   Sequences every access to the external RTC chip over its multiplexed
//   address/data bus (address phase, gap, data phase) and arbitrates the bus
//   between the periodic display read path and the user write path.
//   Each of the five bus phases lasts T_PHASE clocks, timed by an internal
//   phase counter.
//
// Parameters:
//   T_PHASE  clocks per bus phase, legal range 1..255
//
// Ports:
//   clk   system clock, all state changes on the rising edge
//   rst   asynchronous reset, active-low
//   bus   rtc_bus_sequencer_if.slave: request/grant handshake, status and
//         RTC strobes / address-data bus
//
// Timing:
//   All outputs are registered from the current state, so bus values follow
//   the FSM state by one clock. With a grant visible in cycle g, cs_n is low
//   for cycles g+1 .. g+5*T_PHASE and done pulses in cycle g+5*T_PHASE+1.
// ----------------------------------------------------------------------------
module rtc_bus_sequencer #(
    parameter int T_PHASE = 4
) (
    input  logic               clk,
    input  logic               rst,
    rtc_bus_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ADDR_SETUP = 3'd1,
        ADDR_HOLD  = 3'd2,
        GAP        = 3'd3,
        DATA_ACT   = 3'd4,
        DATA_HOLD  = 3'd5,
        DONE       = 3'd6
    } state_t;

    typedef enum logic {
        SERVED_RD = 1'b0,
        SERVED_WR = 1'b1
    } served_t;

    localparam logic [7:0] PHASE_LAST = 8'(T_PHASE - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] phase_cnt;
    logic       phase_end;
    served_t    last_served;

    // Transaction context, captured at accept so that later changes on the
    // request inputs cannot disturb the transaction in flight.
    logic       txn_wr;
    logic [7:0] addr_q;
    logic [7:0] data_q;

    logic       accept;
    logic       accept_wr;

    // Decoded bus values for the current state, registered into the outputs.
    logic       cs_n_d;
    logic       rd_n_d;
    logic       wr_n_d;
    logic       ad_n_d;
    logic       ad_oe_d;
    logic [7:0] ad_out_d;
    logic       done_d;
    logic       busy_d;

    // ------------------------------------------------------------------
    // Next-state logic and arbitration
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin : next_state_logic
        state_next = state;
        accept     = 1'b0;
        accept_wr  = 1'b0;
        phase_end  = (phase_cnt == PHASE_LAST);

        case (state)
            IDLE: begin
                // Requests are only looked at here; anything raised while a
                // transaction runs waits until the FSM is back in IDLE.
                if (bus.rd_req && bus.wr_req) begin
                    accept    = 1'b1;
                    accept_wr = (last_served == SERVED_RD);
                end else if (bus.rd_req) begin
                    accept = 1'b1;
                end else if (bus.wr_req) begin
                    accept    = 1'b1;
                    accept_wr = 1'b1;
                end
                if (accept) begin
                    state_next = ADDR_SETUP;
                end
            end
            ADDR_SETUP: if (phase_end) state_next = ADDR_HOLD;
            ADDR_HOLD:  if (phase_end) state_next = GAP;
            GAP:        if (phase_end) state_next = DATA_ACT;
            DATA_ACT:   if (phase_end) state_next = DATA_HOLD;
            DATA_HOLD:  if (phase_end) state_next = DONE;
            DONE:       state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Per-state bus values
    // ------------------------------------------------------------------
    always_comb begin : output_decode
        cs_n_d   = 1'b1;
        rd_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        ad_n_d   = 1'b1;
        ad_oe_d  = 1'b0;
        ad_out_d = 8'h00;
        done_d   = 1'b0;
        busy_d   = (state != IDLE);

        case (state)
            ADDR_SETUP: begin
                cs_n_d   = 1'b0;
                ad_n_d   = 1'b0;
                wr_n_d   = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = addr_q;
            end
            ADDR_HOLD: begin
                cs_n_d   = 1'b0;
                ad_n_d   = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = addr_q;
            end
            GAP: begin
                // Bus released between address and data so the RTC can turn
                // its drivers around on a read.
                cs_n_d = 1'b0;
            end
            DATA_ACT: begin
                cs_n_d = 1'b0;
                if (txn_wr) begin
                    wr_n_d   = 1'b0;
                    ad_oe_d  = 1'b1;
                    ad_out_d = data_q;
                end else begin
                    rd_n_d = 1'b0;
                end
            end
            DATA_HOLD: begin
                cs_n_d = 1'b0;
                if (txn_wr) begin
                    ad_oe_d  = 1'b1;
                    ad_out_d = data_q;
                end
            end
            DONE: begin
                done_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, phase counter and transaction context
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin : state_reg
        if (!rst) begin
            state       <= IDLE;
            phase_cnt   <= 8'h00;
            last_served <= SERVED_WR;
            txn_wr      <= 1'b0;
            addr_q      <= 8'h00;
            data_q      <= 8'h00;
        end else begin
            state <= state_next;

            // Counter restarts on every state change; IDLE and DONE never
            // count because they do not last a full phase.
            if (state_next != state) begin
                phase_cnt <= 8'h00;
            end else if (state != IDLE) begin
                phase_cnt <= phase_cnt + 8'd1;
            end

            if (accept) begin
                txn_wr      <= accept_wr;
                last_served <= accept_wr ? SERVED_WR : SERVED_RD;
                addr_q      <= accept_wr ? bus.wr_addr : bus.rd_addr;
                data_q      <= bus.wr_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin : output_reg
        if (!rst) begin
            bus.cs_n     <= 1'b1;
            bus.rd_n     <= 1'b1;
            bus.wr_n     <= 1'b1;
            bus.ad_n     <= 1'b1;
            bus.ad_oe    <= 1'b0;
            bus.ad_out   <= 8'h00;
            bus.done     <= 1'b0;
            bus.busy     <= 1'b0;
            bus.grant_rd <= 1'b0;
            bus.grant_wr <= 1'b0;
            bus.rd_data  <= 8'h00;
        end else begin
            bus.cs_n     <= cs_n_d;
            bus.rd_n     <= rd_n_d;
            bus.wr_n     <= wr_n_d;
            bus.ad_n     <= ad_n_d;
            bus.ad_oe    <= ad_oe_d;
            bus.ad_out   <= ad_out_d;
            bus.done     <= done_d;
            bus.busy     <= busy_d;
            bus.grant_rd <= accept && !accept_wr;
            bus.grant_wr <= accept && accept_wr;

            // Capture on the edge where rd_n rises: the strobe output is
            // still low and the FSM has just left DATA_ACT. Only reads ever
            // drive rd_n low, so writes cannot touch rd_data.
            if (!bus.rd_n && (state == DATA_HOLD)) begin
                bus.rd_data <= bus.ad_in;
            end
        end
    end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// ----------------------------------------------------------------------------
// tb_rtc_bus_sequencer
//
// Purpose:
//   Self-checking bench for rtc_bus_sequencer. Two instances are built, one
//   with T_PHASE=4 and one with T_PHASE=1. A table of single-requester
//   transactions runs on the T_PHASE=4 instance, followed by hand-written
//   sequences for arbitration, reset abort and the one-clock-phase case.
//   Outputs are sampled on the falling clock edge; inputs change there too.
// ----------------------------------------------------------------------------
module tb_rtc_bus_sequencer;

    localparam int TP = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rtc_bus_sequencer_if bus4 ();
    rtc_bus_sequencer_if bus1 ();

    rtc_bus_sequencer #(.T_PHASE(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    rtc_bus_sequencer #(.T_PHASE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct packed {
        logic       grant_rd;
        logic       grant_wr;
        logic       done;
        logic       busy;
        logic       cs_n;
        logic       rd_n;
        logic       wr_n;
        logic       ad_n;
        logic       ad_oe;
        logic [7:0] ad_out;
        logic [7:0] rd_data;
    } obs_t;

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] ad_in;
        logic [7:0] exp_rd;
    } vec_t;

    localparam obs_t IDLE_OBS = '{grant_rd: 1'b0, grant_wr: 1'b0, done: 1'b0,
                                  busy: 1'b0, cs_n: 1'b1, rd_n: 1'b1,
                                  wr_n: 1'b1, ad_n: 1'b1, ad_oe: 1'b0,
                                  ad_out: 8'h00, rd_data: 8'h00};

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic obs_t sample(input int sel);
        obs_t o;
        if (sel == 1)
            o = {bus1.grant_rd, bus1.grant_wr, bus1.done, bus1.busy, bus1.cs_n, bus1.rd_n,
                 bus1.wr_n, bus1.ad_n, bus1.ad_oe, bus1.ad_out, bus1.rd_data};
        else
            o = {bus4.grant_rd, bus4.grant_wr, bus4.done, bus4.busy, bus4.cs_n, bus4.rd_n,
                 bus4.wr_n, bus4.ad_n, bus4.ad_oe, bus4.ad_out, bus4.rd_data};
        return o;
    endfunction

    task automatic drive(input int sel, input logic rq, input logic [7:0] ra, input logic wq,
                         input logic [7:0] wa, input logic [7:0] wd, input logic [7:0] ai);
        if (sel == 1) begin
            bus1.rd_req = rq; bus1.rd_addr = ra; bus1.wr_req = wq;
            bus1.wr_addr = wa; bus1.wr_data = wd; bus1.ad_in = ai;
        end else begin
            bus4.rd_req = rq; bus4.rd_addr = ra; bus4.wr_req = wq;
            bus4.wr_addr = wa; bus4.wr_data = wd; bus4.ad_in = ai;
        end
    endtask

    // Expected {cs_n, rd_n, wr_n, ad_n, ad_oe} for cycle k after the grant
    // (k = 1 .. 5*t is the bus, k = 5*t+1 is the done cycle).
    function automatic logic [4:0] exp_strobes(input int k, input int t, input logic wr);
        int p;
        if (k == 5 * t + 1) return 5'b11110;
        p = (k - 1) / t;
        case (p)
            0:       return 5'b01001;
            1:       return 5'b01101;
            2:       return 5'b01110;
            3:       return wr ? 5'b01011 : 5'b00110;
            default: return wr ? 5'b01111 : 5'b01110;
        endcase
    endfunction

    // Waits (bounded) for a grant, scrambles the request inputs, then checks
    // every cycle of the transaction against the expected bus waveform.
    task automatic run_txn(input int sel, input int t, input logic wr, input logic [7:0] addr,
                           input logic [7:0] data, input logic [7:0] exp_rd,
                           input logic [7:0] ad_in, input string tag);
        obs_t       o;
        int         waited;
        logic [4:0] es;
        waited = 0;
        o = sample(sel);
        while (!(o.grant_rd || o.grant_wr) && waited < 40) begin
            @(negedge clk);
            o = sample(sel);
            waited++;
        end
        check({tag, " grant seen"}, 32'(waited < 40), 32'd1);
        if (waited >= 40) return;
        check({tag, " grant kind"}, 32'({o.grant_rd, o.grant_wr}), wr ? 32'd1 : 32'd2);
        check({tag, " grant cycle idle bus"}, 32'({o.busy, o.cs_n}), 32'b01);
        drive(sel, 1'b0, ~addr, 1'b0, ~addr, ~data, ad_in);
        for (int k = 1; k <= 5 * t + 1; k++) begin
            @(negedge clk);
            o  = sample(sel);
            es = exp_strobes(k, t, wr);
            check($sformatf("%s k=%0d strobes", tag, k),
                  32'({o.cs_n, o.rd_n, o.wr_n, o.ad_n, o.ad_oe}), 32'(es));
            if (es[0])
                check($sformatf("%s k=%0d ad_out", tag, k), 32'(o.ad_out),
                      32'((k <= 2 * t) ? addr : data));
            check($sformatf("%s k=%0d ctl", tag, k),
                  32'({o.grant_rd, o.grant_wr, o.done, o.busy}),
                  32'({2'b00, (k == 5 * t + 1), 1'b1}));
        end
        check({tag, " rd_data"}, 32'(o.rd_data), 32'(exp_rd));
        @(negedge clk);
        o = sample(sel);
        check({tag, " back to idle"}, 32'({o.busy, o.done, o.cs_n}), 32'b001);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        obs_t o;
        vec_t vecs [6];
        int   n;
        int   gcyc [4];
        logic gkind [4];
        int   k;
        logic seen_done;

        vecs[0] = '{wr: 1'b1, addr: 8'h22, data: 8'h59, ad_in: 8'hEE, exp_rd: 8'h00};
        vecs[1] = '{wr: 1'b0, addr: 8'h21, data: 8'h00, ad_in: 8'h45, exp_rd: 8'h45};
        vecs[2] = '{wr: 1'b1, addr: 8'hFF, data: 8'h00, ad_in: 8'hA5, exp_rd: 8'h45};
        vecs[3] = '{wr: 1'b0, addr: 8'h00, data: 8'h00, ad_in: 8'hFF, exp_rd: 8'hFF};
        vecs[4] = '{wr: 1'b0, addr: 8'h80, data: 8'h00, ad_in: 8'h3C, exp_rd: 8'h3C};
        vecs[5] = '{wr: 1'b1, addr: 8'h5A, data: 8'hC3, ad_in: 8'h11, exp_rd: 8'h3C};

        // ---------------- reset state ----------------
        rst = 1'b0;
        drive(4, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
        drive(1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
        repeat (3) @(negedge clk);
        check("reset dut4", 32'(sample(4)), 32'(IDLE_OBS));
        check("reset dut1", 32'(sample(1)), 32'(IDLE_OBS));
        rst = 1'b1;
        @(negedge clk);
        check("idle after release", 32'(sample(4)), 32'(IDLE_OBS));

        // ---------------- table of single transactions ----------------
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].wr)
                drive(4, 1'b0, 8'h00, 1'b1, vecs[i].addr, vecs[i].data, vecs[i].ad_in);
            else
                drive(4, 1'b1, vecs[i].addr, 1'b0, 8'h00, 8'h00, vecs[i].ad_in);
            run_txn(4, TP, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].exp_rd,
                    vecs[i].ad_in, $sformatf("vec%0d", i));
        end

        // ---------------- round-robin with both requests held ----------------
        rst = 1'b0;
        @(negedge clk);
        o = sample(4);
        check("reset clears rd_data", 32'(o.rd_data), 32'h00);
        drive(4, 1'b1, 8'h10, 1'b1, 8'h20, 8'h30, 8'h99);
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        for (int c = 1; c <= 200 && n < 4; c++) begin
            @(negedge clk);
            o = sample(4);
            check("rr exclusive grant", 32'(o.grant_rd & o.grant_wr), 32'd0);
            if (o.grant_rd || o.grant_wr) begin
                gcyc[n]  = c;
                gkind[n] = o.grant_wr;
                n++;
            end
        end
        check("rr grant count", 32'(n), 32'd4);
        for (int i = 0; i < n; i++) begin
            check($sformatf("rr grant %0d is wr", i), 32'(gkind[i]), 32'(i % 2));
            if (i > 0)
                check($sformatf("rr spacing %0d", i), 32'(gcyc[i] - gcyc[i-1]), 32'(5 * TP + 2));
        end
        drive(4, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
        repeat (5 * TP + 4) @(negedge clk);
        check("rr drained", 32'(sample(4).busy), 32'd0);

        // ---------------- reset during DATA_ACT of a write ----------------
        drive(4, 1'b0, 8'h00, 1'b1, 8'h44, 8'h77, 8'h00);
        k = 0;
        o = sample(4);
        while (!o.grant_wr && k < 40) begin
            @(negedge clk);
            o = sample(4);
            k++;
        end
        check("abort grant_wr", 32'(o.grant_wr), 32'd1);
        drive(4, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00);
        repeat (3 * TP + 2) @(negedge clk);
        o = sample(4);
        check("abort in DATA_ACT", 32'({o.cs_n, o.wr_n, o.ad_oe, o.ad_out}), 32'({3'b001, 8'h77}));
        drive(4, 1'b1, 8'h66, 1'b1, 8'h44, 8'h77, 8'h5D);
        #2 rst = 1'b0;
        #1 o = sample(4);
        check("abort async strobes", 32'({o.cs_n, o.wr_n, o.ad_oe, o.done, o.busy}), 32'b11000);
        seen_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            o = sample(4);
            seen_done |= o.done;
        end
        rst = 1'b1;
        @(negedge clk);
        o = sample(4);
        seen_done |= o.done;
        check("abort no done", 32'(seen_done), 32'd0);
        check("abort read granted first", 32'({o.grant_rd, o.grant_wr}), 32'b10);
        run_txn(4, TP, 1'b0, 8'h66, 8'h00, 8'h5D, 8'h5D, "post-abort read");

        // ---------------- T_PHASE=1 ----------------
        drive(1, 1'b1, 8'h33, 1'b0, 8'h00, 8'h00, 8'h7C);
        run_txn(1, 1, 1'b0, 8'h33, 8'h00, 8'h7C, 8'h7C, "t1 read");
        drive(1, 1'b0, 8'h00, 1'b1, 8'hA0, 8'h0B, 8'h12);
        run_txn(1, 1, 1'b1, 8'hA0, 8'h0B, 8'h7C, 8'h12, "t1 write");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rtc_bus_sequencer.md
Name: rtc_bus_sequencer

Overview:
- Sequences every access to the external RTC chip's multiplexed address/data bus (Intel-style: address phase, then data phase, under cs_n/rd_n/wr_n/ad_n).
- Arbitrates the bus between two requesters:
  - the periodic time/date read path that feeds the VGA display;
  - the user write path that sets time and alarm.
- Phase timing comes from an internal programmable wait counter, so no separate delay counter is needed upstream.

Parameters:
- T_PHASE, 4, clocks per bus phase; legal range 1..255.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous reset, active-low.
- rd_req  in  1  read request (requester 0), level.
- rd_addr  in  8  RTC register address for the read.
- wr_req  in  1  write request (requester 1), level.
- wr_addr  in  8  RTC register address for the write.
- wr_data  in  8  write data.
- grant_rd  out  1  one-cycle pulse: read accepted; rd_addr latched in that cycle.
- grant_wr  out  1  one-cycle pulse: write accepted; wr_addr/wr_data latched in that cycle.
- done  out  1  one-cycle pulse at transaction end.
- busy  out  1  high whenever FSM is not in IDLE.
- rd_data  out  8  last read result; holds until the next read completes.
- cs_n, rd_n, wr_n, ad_n  out  1 each  RTC strobes; ad_n=0 means the bus carries an address.
- ad_oe  out  1  tristate enable for ad_out.
- ad_out  out  8  value driven onto the bus.
- ad_in  in  8  value sampled from the bus.

Behaviour:
- Reset (rst=0, async): FSM=IDLE, phase counter=0, last_served=WR.
  - Outputs: cs_n=rd_n=wr_n=ad_n=1; ad_oe=0; ad_out=0; rd_data=0; grant_rd=grant_wr=done=busy=0.
  - Asserting reset mid-transaction aborts immediately: strobes return to idle and no done is issued.
- All outputs are registered. Values listed per state are those held while the FSM is in that state.
- States and per-state bus values:
  - IDLE: all strobes high, ad_oe=0.
  - ADDR_SETUP: cs_n=0, ad_n=0, wr_n=0, ad_oe=1, ad_out=address.
  - ADDR_HOLD: cs_n=0, ad_n=0, wr_n=1, ad_oe=1, ad_out=address.
  - GAP: cs_n=0, ad_n=1, ad_oe=0.
  - DATA_ACT:
    - read: rd_n=0, ad_oe=0;
    - write: wr_n=0, ad_oe=1, ad_out=data.
  - DATA_HOLD:
    - read: rd_n=1;
    - write: wr_n=1, ad_oe=1, ad_out=data held.
  - DONE: cs_n=1, ad_oe=0, done=1.
- Phase counter:
  - Counts 0..T_PHASE-1; each of the five bus states lasts exactly T_PHASE clocks.
  - Counter clears on every state change.
  - T_PHASE=1 gives one clock per phase.
- Transitions:
  - IDLE→ADDR_SETUP on accept.
  - ADDR_SETUP→ADDR_HOLD→GAP→DATA_ACT→DATA_HOLD→DONE, each on count==T_PHASE-1.
  - DONE→IDLE unconditionally after 1 cycle.
- Latency: grant at cycle g; cs_n low for cycles g+1 .. g+5·T_PHASE; done at cycle g+5·T_PHASE+1.
- Read capture: rd_data ← ad_in on the last clock of DATA_ACT, i.e. before rd_n rises. rd_data is never changed by a write.
- Arbitration (evaluated only in IDLE):
  - Requests are sampled only in IDLE; requests in other states are ignored (not queued).
  - One requester asserting: grant it.
  - Both asserting: grant the one not equal to last_served, then update last_served (round-robin). The first conflict after reset goes to read.
  - A request held high through done starts a new transaction on the IDLE cycle following DONE, giving a minimum of 1 idle cycle between transactions.
  - Address and data are latched at grant; later changes on the inputs have no effect on the transaction in flight.
- Never more than one grant per transaction; grant_rd and grant_wr are never high together.

Test Plan:
- Single read, T_PHASE=4, rd_addr=0x21, ad_in=0x45:
  - grant_rd pulse at g; cs_n low for 20 cycles; ad_out=0x21 with ad_oe=1 for 8 cycles; rd_n low for 4 cycles;
  - done at g+21; rd_data=0x45; busy low at g+22.
- Single write, T_PHASE=4, wr_addr=0x22, wr_data=0x59:
  - ad_out=0x22 for 8 cycles, then ad_oe=0 for 4 cycles, then ad_out=0x59 with ad_oe=1 for 8 cycles;
  - wr_n low during ADDR_SETUP and DATA_ACT only; rd_data unchanged at 0.
- rd_req and wr_req both held high from reset release:
  - grant order is rd, wr, rd, wr;
  - consecutive grants spaced by 5·T_PHASE+2 cycles.
- rst driven low during DATA_ACT of a write:
  - cs_n/wr_n=1 and ad_oe=0 asynchronously; no done pulse;
  - after release, FSM is in IDLE and a pending rd_req is granted first.
- T_PHASE=1 read with rd_addr changed right after grant:
  - transaction completes in 6 cycles;
  - bus shows the originally latched address.
